// File: rtl/logic_unit_pkg.sv
// Shared constants for the pipelined bitwise logic unit: opcode encodings and default width.
package logic_unit_pkg;

    localparam int OP_W          = 3;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic [OP_W-1:0] OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation on already-inverted operands; sits between S1 and S2.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = ~(a ^ b);
            OP_NOTA:  result = ~a;
            OP_PASSA: result = a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit (S1 operands, S2 result).
// Optional zero/parity flags on the result are enabled with LOGIC_FLAGS_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef LOGIC_FLAGS_EN
    ,
    output logic             flag_zero,
    output logic             flag_parity
`endif
);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (drives out_valid)
    logic [2:1]       vld_pipe;
    s1_t              s1_q;
    logic [WIDTH-1:0] core_res;
    logic             s2_free;
    logic             s1_adv;
    logic             in_xfer;

    assign s2_free   = !vld_pipe[2] || out_ready;
    assign s1_adv    = vld_pipe[1] && s2_free;
    assign in_ready  = !vld_pipe[1] || s2_free;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_xfer || (vld_pipe[1] && !s1_adv);
            vld_pipe[2] <= s1_adv || (vld_pipe[2] && !out_ready);
        end
    end

    // Inversion is folded in before S1 so the core only sees effective operands
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else if (in_xfer) begin
            s1_q.op <= op;
            s1_q.a  <= inv_a ? ~a : a;
            s1_q.b  <= inv_b ? ~b : b;
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (s1_q.op),
        .a      (s1_q.a),
        .b      (s1_q.b),
        .result (core_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (s1_adv) begin
            result <= core_res;
        end
    end

`ifdef LOGIC_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zero   <= 1'b0;
            flag_parity <= 1'b0;
        end else if (s1_adv) begin
            flag_zero   <= (core_res == '0);
            flag_parity <= ^core_res;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table, directed stall/reset sequences,
// and random traffic against a queue-based scoreboard.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OP_W-1:0] op = '0;
    logic            inv_a = 1'b0;
    logic            inv_b = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    result;
`ifdef LOGIC_FLAGS_EN
    logic            flag_zero;
    logic            flag_parity;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .inv_a       (inv_a),
        .inv_b       (inv_b),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
`ifdef LOGIC_FLAGS_EN
        ,
        .flag_zero   (flag_zero),
        .flag_parity (flag_parity)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_in   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: the operation table written straight from the opcode definitions
    function automatic logic [W-1:0] model(input logic [OP_W-1:0] o, input logic ia, input logic ib,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] ea, eb;
        ea = ia ? ~x : x;
        eb = ib ? ~y : y;
        case (o)
            3'd0: return ea & eb;
            3'd1: return ea | eb;
            3'd2: return ~(ea & eb);
            3'd3: return ~(ea | eb);
            3'd4: return ea ^ eb;
            3'd5: return ~(ea ^ eb);
            3'd6: return ~ea;
            default: return ea;
        endcase
    endfunction

    // Scoreboard monitor, sampled on the falling edge so handshakes are settled
    logic [W-1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res   = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_result", 32'(result), 32'(prev_res));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected no beat", result);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("scoreboard_result", 32'(result), 32'(e));
`ifdef LOGIC_FLAGS_EN
                    check("scoreboard_zero", 32'(flag_zero), 32'(e == '0));
                    check("scoreboard_parity", 32'(flag_parity), 32'(^e));
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, inv_a, inv_b, a, b));
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
        end
    end

    typedef struct {
        logic [OP_W-1:0] op;
        logic            ia;
        logic            ib;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [W-1:0]    exp;
    } vec_t;

    vec_t tbl[11];

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        op       = v.op;
        inv_a    = v.ia;
        inv_b    = v.ib;
        a        = v.a;
        b        = v.b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'hC0};
        tbl[1]  = '{3'd1, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'hFC};
        tbl[2]  = '{3'd2, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'h3F};
        tbl[3]  = '{3'd3, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'h03};
        tbl[4]  = '{3'd4, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'h3C};
        tbl[5]  = '{3'd5, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'hC3};
        tbl[6]  = '{3'd6, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'h0F};
        tbl[7]  = '{3'd7, 1'b0, 1'b0, 8'hF0, 8'hCC, 8'hF0};
        tbl[8]  = '{3'd0, 1'b1, 1'b0, 8'hF0, 8'hCC, 8'h0C};
        tbl[9]  = '{3'd1, 1'b0, 1'b1, 8'hF0, 8'hCC, 8'hF3};
        tbl[10] = '{3'd4, 1'b1, 1'b1, 8'hF0, 8'hCC, 8'h3C};

        // Reset state
        repeat (2) tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'h00);
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back table: result for entry i-1 visible right after entry i transfers
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i]);
            tick();
            if (i == 0) begin
                check("latency_not_early", 32'(out_valid), 32'd0);
            end else begin
                check($sformatf("tbl_valid[%0d]", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("tbl_result[%0d]", i - 1), 32'(result), 32'(tbl[i - 1].exp));
            end
        end
        in_valid = 1'b0;
        tick();
        check("tbl_valid[10]", 32'(out_valid), 32'd1);
        check("tbl_result[10]", 32'(result), 32'(tbl[10].exp));
        tick();
        check("tbl_drained", 32'(out_valid), 32'd0);

        // Backpressure: two beats buffered, third held off
        out_ready = 1'b0;
        drive(tbl[0]);
        tick();
        check("bp_ready_1", 32'(in_ready), 32'd1);
        drive(tbl[1]);
        tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_result_c0", 32'(result), 32'hC0);
        check("bp_full", 32'(in_ready), 32'd0);
        drive(tbl[4]);
        repeat (2) begin
            tick();
            check("bp_full_hold", 32'(in_ready), 32'd0);
            check("bp_result_hold", 32'(result), 32'hC0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_result_fc", 32'(result), 32'hFC);
        tick();
        check("bp_valid_3c", 32'(out_valid), 32'd1);
        check("bp_result_3c", 32'(result), 32'h3C);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        drive(tbl[0]);
        tick();
        drive(tbl[1]);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", 32'(result), 32'h00);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef LOGIC_FLAGS_EN
        drive('{3'd4, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'h00});
        tick();
        in_valid = 1'b0;
        tick();
        check("flag_xor_result", 32'(result), 32'h00);
        check("flag_xor_zero", 32'(flag_zero), 32'd1);
        check("flag_xor_parity", 32'(flag_parity), 32'd0);
        drive('{3'd1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h01});
        tick();
        in_valid = 1'b0;
        tick();
        check("flag_or_result", 32'(result), 32'h01);
        check("flag_or_zero", 32'(flag_zero), 32'd0);
        check("flag_or_parity", 32'(flag_parity), 32'd1);
        tick();
`endif

        // Random traffic; monitor checks ordering and stall stability
        begin
            int start_in;
            int cyc;
            start_in = n_in;
            cyc = 0;
            while ((n_in - start_in) < 1000 && cyc < 6000) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                op        = OP_W'($urandom_range(0, 7));
                inv_a     = 1'($urandom_range(0, 1));
                inv_b     = 1'($urandom_range(0, 1));
                a         = W'($urandom);
                b         = W'($urandom);
                tick();
                cyc++;
            end
            if (cyc >= 6000) begin
                n_chk++;
                n_fail++;
                $display("FAIL random_budget: accepted %0d beats, required 1000", n_in - start_in);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
